// File: rtl/mem_arbiter.sv
// Arbiter for the unified main-memory port shared by the icache and dcache controllers.
// Dcache has priority, limited by a starvation counter; a write-back plus its fill runs as one sequence.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_inProg,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IRD  = 2'd1,
    DRD  = 2'd2,
    DWR  = 2'd3
  } state_t;

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic              fill_pending, fill_nxt;

  logic d_req;
  logic grant_d;
  logic grant_i;

  // Grant decision; only acted upon while IDLE.
  always_comb begin
    d_req   = d_re | d_we;
    grant_d = d_req & (~i_re | (starve_cnt < CNT_MAX));
    grant_i = i_re & ~grant_d;
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  // NOTE: address/data holding registers are reset too, so mem_addr/mem_wdata read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fill_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      starve_cnt   <= starve_nxt;
      addr_q       <= addr_nxt;
      wdata_q      <= wdata_nxt;
      fill_pending <= fill_nxt;
    end
  end

  // Next-state and register-load logic.
  // NOTE: every signal gets a hold default up front so no path through the case infers a latch.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    fill_nxt   = fill_pending;

    unique case (state)
      IDLE: begin
        if (grant_d) begin
          if (i_re) begin
            starve_nxt = (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + 1'b1;
          end else begin
            starve_nxt = '0;
          end
          if (d_we) begin
            state_nxt = DWR;
            addr_nxt  = d_wb_addr;
            wdata_nxt = d_wdata;
            fill_nxt  = d_re;
          end else begin
            state_nxt = DRD;
            addr_nxt  = d_addr;
            fill_nxt  = 1'b0;
          end
        end else if (grant_i) begin
          state_nxt  = IRD;
          addr_nxt   = i_addr;
          starve_nxt = '0;
        end else begin
          starve_nxt = '0;
        end
      end

      IRD: begin
        if (mem_rdy) state_nxt = IDLE;
      end

      DRD: begin
        if (mem_rdy) state_nxt = IDLE;
      end

      DWR: begin
        // The fill address is sampled when the write-back finishes, not at grant.
        if (mem_rdy) begin
          if (fill_pending) begin
            state_nxt = DRD;
            addr_nxt  = d_addr;
            fill_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. Return data is gated so both data buses idle at 0 outside a completion.
  always_comb begin
    mem_re    = (state == IRD) | (state == DRD);
    mem_we    = (state == DWR);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_rdy     = (state == IRD) & mem_rdy;
    d_rdy     = ((state == DRD) & mem_rdy) | ((state == DWR) & mem_rdy & ~fill_pending);
    i_rdata   = i_rdy ? mem_rdata : '0;
    d_rdata   = ((state == DRD) & mem_rdy) ? mem_rdata : '0;
    d_inProg  = (state == DRD) | (state == DWR) | d_re | d_we;
  end

  a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(mem_re && mem_we));
  a_rdy_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(i_rdy && d_rdy));
  a_idle_after_done: assert property (@(posedge clk) disable iff (!rst_n)
                                      (i_rdy || d_rdy) |=> (state == IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized traffic,
// compared each cycle against a transaction-queue reference model.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;
  localparam int STARVE_MAX = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_re;
  logic [ADDR_W-1:0] i_addr;
  logic              i_rdy;
  logic [DATA_W-1:0] i_rdata;
  logic              d_re, d_we;
  logic [ADDR_W-1:0] d_addr, d_wb_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rdy;
  logic [DATA_W-1:0] d_rdata;
  logic              d_inProg;
  logic              mem_re, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_re(i_re), .i_addr(i_addr), .i_rdy(i_rdy), .i_rdata(i_rdata),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wb_addr(d_wb_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata), .d_inProg(d_inProg),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: the memory operations still owed by the current transaction.
  typedef struct {
    bit              we;
    bit              owner_d;
    bit              fin;
    bit              live;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } op_t;

  op_t ops[$];
  int  starve;

  int n_checks = 0;
  int n_errors = 0;
  int i_pulses = 0;
  int d_pulses = 0;
  bit auto_mem = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic op_t mk_op(bit we, bit owner_d, bit fin, bit live,
                                logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] data);
    op_t o;
    o.we = we; o.owner_d = owner_d; o.fin = fin; o.live = live;
    o.addr = addr; o.data = data;
    return o;
  endfunction

  task automatic check_outputs();
    bit  busy;
    op_t f;
    bit  e_ir, e_dr;
    busy = (ops.size() != 0);
    f = busy ? ops[0] : mk_op(0, 0, 0, 0, '0, '0);
    if (!rst_n) begin
      check("rst_mem_re",    64'(mem_re),    64'(0));
      check("rst_mem_we",    64'(mem_we),    64'(0));
      check("rst_i_rdy",     64'(i_rdy),     64'(0));
      check("rst_d_rdy",     64'(d_rdy),     64'(0));
      check("rst_mem_addr",  64'(mem_addr),  64'(0));
      check("rst_mem_wdata", mem_wdata,      64'(0));
      check("rst_i_rdata",   i_rdata,        64'(0));
      check("rst_d_rdata",   d_rdata,        64'(0));
      check("rst_d_inProg",  64'(d_inProg),  64'(d_re | d_we));
      return;
    end
    e_ir = busy && !f.owner_d && mem_rdy;
    e_dr = busy && f.owner_d && f.fin && mem_rdy;
    check("mem_re",   64'(mem_re),   64'(busy && !f.we));
    check("mem_we",   64'(mem_we),   64'(busy && f.we));
    check("i_rdy",    64'(i_rdy),    64'(e_ir));
    check("d_rdy",    64'(d_rdy),    64'(e_dr));
    check("d_inProg", 64'(d_inProg), 64'((busy && f.owner_d) || d_re || d_we));
    if (busy) check("mem_addr", 64'(mem_addr), 64'(f.addr));
    if (busy && f.we) check("mem_wdata", mem_wdata, f.data);
    if (e_ir) check("i_rdata", i_rdata, mem_rdata);
    if (e_dr && !f.we) check("d_rdata", d_rdata, mem_rdata);
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees at that edge.
  task automatic model_step();
    op_t o;
    if (!rst_n) return;
    if (ops.size() != 0) begin
      if (mem_rdy) begin
        void'(ops.pop_front());
        if (ops.size() != 0 && ops[0].live) begin
          o = ops[0];
          o.addr = d_addr;
          o.live = 1'b0;
          ops[0] = o;
        end
      end
    end else if ((d_re || d_we) && (!i_re || starve < STARVE_MAX)) begin
      starve = i_re ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
      if (d_we) begin
        ops.push_back(mk_op(1, 1, !d_re, 0, d_wb_addr, d_wdata));
        if (d_re) ops.push_back(mk_op(0, 1, 1, 1, '0, '0));
      end else begin
        ops.push_back(mk_op(0, 1, 1, 0, d_addr, '0));
      end
    end else if (i_re) begin
      starve = 0;
      ops.push_back(mk_op(0, 0, 1, 0, i_addr, '0));
    end else begin
      starve = 0;
    end
  endtask

  // One clock: check at negedge, step model at posedge, then requesters react.
  task automatic cycle();
    bit got_i, got_d, last_rdy;
    @(negedge clk);
    check_outputs();
    got_i = i_rdy;
    got_d = d_rdy;
    if (i_rdy) i_pulses++;
    if (d_rdy) d_pulses++;
    @(posedge clk);
    model_step();
    #1;
    if (got_i) i_re = 1'b0;
    if (got_d) begin
      d_re = 1'b0;
      d_we = 1'b0;
    end
    last_rdy = mem_rdy;
    mem_rdy = 1'b0;
    if (auto_mem) begin
      mem_rdy   = !last_rdy && (mem_re || mem_we) && ($urandom_range(0, 1) == 1);
      mem_rdata = {$urandom, $urandom};
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_re = 1'b0; d_re = 1'b0; d_we = 1'b0; mem_rdy = 1'b0;
    ops.delete();
    starve = 0;
  endtask

  int  i0, d0;
  bit  hit;
  bit [1:0] r;

  initial begin
    i_addr = '0; d_addr = '0; d_wb_addr = '0; d_wdata = '0; mem_rdata = '0;
    do_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    // Icache miss alone, response 4 cycles after grant.
    i0 = i_pulses;
    i_re = 1'b1; i_addr = 16'h0040;
    cycle();
    repeat (3) cycle();
    mem_rdy = 1'b1; mem_rdata = 64'hDEAD_BEEF_0123_4567;
    cycle();
    repeat (3) cycle();
    check("ic_alone_pulses", 64'(i_pulses - i0), 64'(1));

    // Dirty eviction: write-back then fill, one d_rdy.
    auto_mem = 1'b1;
    d0 = d_pulses;
    d_we = 1'b1; d_re = 1'b1; d_wb_addr = 16'h1000; d_addr = 16'h2000;
    d_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
    cycle();
    check("evict_wr_first_we",   64'(mem_we),   64'(1));
    check("evict_wr_first_addr", 64'(mem_addr), 64'(16'h1000));
    repeat (40) cycle();
    check("evict_d_pulses", 64'(d_pulses - d0), 64'(1));

    // Simultaneous requests with starve count clear: dcache first.
    i0 = i_pulses; d0 = d_pulses;
    i_re = 1'b1; i_addr = 16'h0080; d_re = 1'b1; d_addr = 16'h3000;
    cycle();
    check("simul_first_addr", 64'(mem_addr), 64'(16'h3000));
    check("simul_d_inProg",   64'(d_inProg), 64'(1));
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      cycle();
      if (i_pulses != i0) begin
        hit = 1'b1;
        check("simul_d_before_i", 64'(d_pulses - d0), 64'(1));
      end
    end
    check("simul_i_served", 64'(hit), 64'(1));
    repeat (10) cycle();

    // Starvation: dcache re-requests after every completion while i_re stays high.
    i0 = i_pulses; d0 = d_pulses;
    i_re = 1'b1; i_addr = 16'h0100; d_re = 1'b1; d_addr = 16'h4000;
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      cycle();
      if (i_pulses != i0) begin
        hit = 1'b1;
        check("starve_d_grants", 64'(d_pulses - d0), 64'(STARVE_MAX));
      end else if (!d_re && !d_we) begin
        d_re = 1'b1;
        d_addr = 16'($urandom);
      end
    end
    check("starve_i_served", 64'(hit), 64'(1));
    repeat (40) cycle();

    // Counter cleared: a fresh simultaneous request goes to dcache again.
    i_re = 1'b1; i_addr = 16'h0180; d_re = 1'b1; d_addr = 16'h5000;
    cycle();
    check("starve_cleared_addr", 64'(mem_addr), 64'(16'h5000));
    repeat (60) cycle();

    // Reset two cycles into IRD; a stray mem_rdy afterwards is ignored.
    auto_mem = 1'b0;
    i0 = i_pulses;
    i_re = 1'b1; i_addr = 16'h0200;
    cycle();
    check("rst_ird_entered", 64'(mem_re), 64'(1));
    cycle(); cycle();
    do_reset();
    cycle();
    rst_n = 1'b1;
    cycle();
    mem_rdy = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    cycle();
    check("rst_ird_no_rdy", 64'(i_pulses - i0), 64'(0));
    check("rst_ird_mem_re", 64'(mem_re), 64'(0));

    // Idle noise on mem_rdy.
    i0 = i_pulses; d0 = d_pulses;
    for (int k = 0; k < 8; k++) begin
      mem_rdy = k[0];
      cycle();
    end
    check("noise_no_pulses", 64'((i_pulses - i0) + (d_pulses - d0)), 64'(0));

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      if (rst_n) begin
        if (!i_re && $urandom_range(0, 3) == 0) begin
          i_re = 1'b1;
          i_addr = 16'($urandom);
        end
        if (!d_re && !d_we && $urandom_range(0, 3) == 0) begin
          r = 2'($urandom_range(1, 3));
          d_re = r[0];
          d_we = r[1];
          d_addr = 16'($urandom);
          d_wb_addr = 16'($urandom);
          d_wdata = {$urandom, $urandom};
        end
        mem_rdy = ($urandom_range(0, 2) == 0);
        mem_rdata = {$urandom, $urandom};
      end
      cycle();
    end
    check("random_saw_i", 64'(i_pulses > 10), 64'(1));
    check("random_saw_d", 64'(d_pulses > 10), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single unified main-memory port between the instruction-cache controller and the data-cache controller.
- Sits directly downstream of the icache control FSM, whose mem_re drives i_re here:
  - it consumes that request;
  - it returns the irdy pulse (i_rdy) and the fill line;
  - it returns d_inProg, which the icache uses to defer new misses.
- Dcache has priority, bounded by a starvation counter. A dirty-eviction write-back followed by a fill is performed as one atomic sequence.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 64, cache line width (one memory transfer).
- STARVE_MAX, 3, consecutive dcache grants tolerated while i_re is pending; the next grant then goes to icache.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_re  in  1  icache miss request; level, held until i_rdy
- i_addr  in  ADDR_W  icache line address
- i_rdy  out  1  one-cycle pulse; i_rdata valid this cycle
- i_rdata  out  DATA_W  fill line to icache
- d_re  in  1  dcache read (fill) request; level, held until d_rdy
- d_we  in  1  dcache write-back request; level, held until d_rdy
- d_addr  in  ADDR_W  dcache fill address
- d_wb_addr  in  ADDR_W  dcache write-back address
- d_wdata  in  DATA_W  write-back line
- d_rdy  out  1  one-cycle pulse at end of the dcache sequence
- d_rdata  out  DATA_W  fill line to dcache
- d_inProg  out  1  dcache transaction active or pending
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rdy  in  1  memory completion pulse, one cycle

Behaviour:
- Reset:
  - state IDLE, starve_cnt 0, address/data registers 0.
  - All outputs 0, including i_rdy, d_rdy, mem_re, mem_we and d_inProg (given no requests).
- States: IDLE, IRD, DRD, DWR.
- Grant in IDLE, evaluated every cycle:
  - No request: stay IDLE.
  - Only a dcache request: grant dcache.
  - Only i_re: grant icache.
  - i_re plus a dcache request: grant dcache if starve_cnt < STARVE_MAX, otherwise grant icache.
- Granted dcache:
  - d_we=1: go to DWR; latch d_wb_addr, d_wdata and the flag fill_pending = d_re.
  - d_we=0, d_re=1: go to DRD; latch d_addr.
- Granted icache: go to IRD; latch i_addr.
- Grant latches address/data; mem_addr and mem_wdata come from these registers, never from live inputs.
- mem_re is 1 throughout IRD and DRD. mem_we is 1 throughout DWR. Both are 0 in IDLE.
- IRD: on mem_rdy, i_rdy=1 combinationally that cycle, i_rdata=mem_rdata (passthrough); next state IDLE.
- DWR:
  - On mem_rdy with fill_pending=1: next state DRD; latch d_addr; no d_rdy.
  - On mem_rdy with fill_pending=0: d_rdy=1; next state IDLE.
- DRD: on mem_rdy, d_rdy=1, d_rdata=mem_rdata; next state IDLE.
- Latency:
  - A grant registers one cycle after the request is seen in IDLE.
  - rdy is returned in the same cycle as mem_rdy.
  - At least one IDLE cycle follows every completion, so a requester dropping its request after rdy is never re-granted.
- d_inProg = (state==DRD) | (state==DWR) | d_re | d_we, combinational. This lets the icache see pending dcache activity in the same cycle.
- starve_cnt:
  - Increments on a dcache grant while i_re=1, saturating at STARVE_MAX.
  - Clears on an icache grant or whenever i_re=0 in IDLE.
- mem_rdy in IDLE is ignored: no state change, no rdy pulse.
- Reset asserted mid-transaction: immediate return to IDLE and all outputs 0. A later stray mem_rdy is ignored.
- d_re/d_we/i_re deasserted while their transaction is in flight: the transaction completes anyway and the rdy pulse is still issued.

Test Plan:
- Icache miss alone: i_re=1, i_addr=0x0040, memory responds 4 cycles after grant with 0xDEAD_BEEF_0123_4567 -> mem_re=1 and mem_addr=0x0040 for the whole IRD state; one i_rdy pulse carrying that data; d_inProg=0 throughout.
- Dirty eviction: d_we=1 and d_re=1, d_wb_addr=0x1000, d_addr=0x2000 -> DWR with mem_we=1 at 0x1000, then DRD with mem_re=1 at 0x2000; exactly one d_rdy, at the end of DRD; none after DWR.
- Simultaneous requests: i_re=1 and d_re=1 in the same IDLE cycle with starve_cnt=0 -> dcache granted first, d_inProg=1, icache served on the following grant.
- Starvation: i_re held while a new d_re is presented after each completion -> exactly 3 dcache grants, then an IRD grant, starve_cnt=0 afterwards.
- Reset mid-IRD: assert rst_n=0 two cycles into IRD, then release -> state IDLE; mem_re=0; a mem_rdy pulse after release produces no i_rdy.
- Idle noise: mem_rdy pulsed with no requests present -> no i_rdy or d_rdy, state remains IDLE.
